line_fill_unit: RTL and testbench
=================================

Name: line_fill_unit

Overview:
- Memory-side stage directly downstream of the cache controller FSM.
- Converts its line-level read_en_mem/write_en_mem requests into word-by-word bursts on a simple req/ack main-memory bus.
- Buffers one write-back line so the controller's short write_en_mem pulse is never lost.
- Returns the refilled line with a one-cycle ready_mem pulse that drives WRITE_ALLOCATE -> REFILL_DONE.

Parameters:
ADDR_WIDTH, 32, byte address width.
WORD_WIDTH, 32, memory bus data width; multiple of 8.
WORDS_PER_LINE, 4, words per cache line; power of 2, >= 2.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
read_en_mem  input  1  line read request (level) from controller
write_en_mem  input  1  line write-back request from controller (asserted 1-2 cycles)
rd_addr  input  ADDR_WIDTH  byte address of line to fetch
wb_addr  input  ADDR_WIDTH  byte address of dirty line being evicted
wb_line  input  WORD_WIDTH*WORDS_PER_LINE  dirty line data
ready_mem  output  1  one-cycle pulse: rd_line valid, refill may be written
rd_line  output  WORD_WIDTH*WORDS_PER_LINE  fetched line, word 0 in LSBs
busy  output  1  state != IDLE or write-back pending
protocol_err  output  1  sticky: write-back request dropped
mem_req  output  1  memory word request
mem_we  output  1  1 = write word, 0 = read word
mem_addr  output  ADDR_WIDTH  word byte address
mem_wdata  output  WORD_WIDTH  write data
mem_ack  input  1  memory accepted/completed current word
mem_rdata  input  WORD_WIDTH  read data, valid when mem_ack=1 and mem_we=0

Behaviour:
- Reset (async, any state): state IDLE; wb_pending, edge register, word counter, protocol_err, ready_mem, mem_req, mem_we = 0; mem_addr, mem_wdata, rd_line = 0.
- Write capture:
  - Rising edge of write_en_mem (write_en_mem=1 and registered previous value=0) latches wb_addr (offset bits forced to 0) and wb_line, and sets wb_pending.
  - Capture is independent of state.
  - A rising edge while wb_pending=1 or while in WB_BURST is dropped and sets protocol_err; protocol_err clears only on reset.
- States:
  - IDLE:
    - wb_pending=1 -> WB_BURST; wb_pending cleared on entry. Write-back has priority over a simultaneous read_en_mem.
    - Else read_en_mem=1 -> RD_BURST; rd_addr latched with offset bits forced to 0.
    - A capture edge and a read in the same IDLE cycle: the write is captured and the next IDLE cycle enters WB_BURST.
  - WB_BURST: mem_req=1, mem_we=1, mem_addr=line base + cnt*(WORD_WIDTH/8), mem_wdata=word cnt. Each cycle with mem_ack=1 increments cnt. Ack on the last word -> IDLE, cnt=0.
  - RD_BURST: mem_req=1, mem_we=0, same address rule. On mem_ack, mem_rdata is stored into word cnt of rd_line. Ack on the last word -> RD_DONE, cnt=0.
  - RD_DONE: ready_mem=1 for exactly this cycle -> IDLE.
- read_en_mem is level-sampled only in IDLE. A deassertion during RD_BURST does not abort the burst.
- rd_line holds its value until overwritten by the next read burst.
- mem_req and mem_addr stay stable while waiting for ack. Memory side has one word in flight; no pipelining.
- Latency: zero-wait memory gives 1 IDLE cycle + WORDS_PER_LINE burst cycles + RD_DONE.
  - Clean miss: ready_mem in the (WORDS_PER_LINE+1)th cycle after read_en_mem is first seen in IDLE.
  - Dirty miss: an extra WORDS_PER_LINE+1 cycles ahead of that.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- All outputs registered or decoded from state only; no combinational path from mem_ack to mem_req.

Test Plan:
- Clean read: read_en_mem=1, rd_addr=0x1004, zero-wait ack, mem_rdata=0xA0+cnt.
  - Reads at 0x1000/04/08/0C.
  - ready_mem pulses 1 cycle, 5 cycles after request.
  - rd_line=0x000000A3_000000A2_000000A1_000000A0.
- Dirty miss: write_en_mem high 2 cycles with wb_addr=0x2000, wb_line words 0x11..0x44; read_en_mem rises 2 cycles later with rd_addr=0x3000.
  - Writes 0x11@0x2000 through 0x44@0x200C, then reads from 0x3000.
  - Single ready_mem pulse; protocol_err=0.
- Wait states: mem_ack high only every 3rd cycle.
  - mem_req/mem_addr stay constant across stalls.
  - Exactly 4 acks consumed; ready_mem after 12 burst cycles.
- Simultaneous: write rising edge and read_en_mem=1 in the same IDLE cycle.
  - Write burst completes fully before the first read word is requested.
- Overflow: second write_en_mem rising edge during WB_BURST.
  - protocol_err=1 and stays 1.
  - First write-back data unchanged.
- Reset mid RD_BURST after 2 acks.
  - mem_req=0 immediately; ready_mem never pulses.
  - A new read afterwards starts again at word 0.

Source files
------------

// File: rtl/line_fill_unit.sv
// Memory-side line fill stage: turns line-level read / write-back requests from the
// cache controller into word-by-word req/ack bursts, buffering one write-back line.
module line_fill_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int WORD_WIDTH     = 32,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 read_en_mem,
    input  logic                                 write_en_mem,
    input  logic [ADDR_WIDTH-1:0]                rd_addr,
    input  logic [ADDR_WIDTH-1:0]                wb_addr,
    input  logic [WORD_WIDTH*WORDS_PER_LINE-1:0] wb_line,
    output logic                                 ready_mem,
    output logic [WORD_WIDTH*WORDS_PER_LINE-1:0] rd_line,
    output logic                                 busy,
    output logic                                 protocol_err,
    output logic                                 mem_req,
    output logic                                 mem_we,
    output logic [ADDR_WIDTH-1:0]                mem_addr,
    output logic [WORD_WIDTH-1:0]                mem_wdata,
    input  logic                                 mem_ack,
    input  logic [WORD_WIDTH-1:0]                mem_rdata
);

    localparam int                  CW       = $clog2(WORDS_PER_LINE);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(WORDS_PER_LINE * (WORD_WIDTH / 8) - 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(WORD_WIDTH / 8);
    localparam logic [CW-1:0]         LAST     = CW'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {IDLE, WB_BURST, RD_BURST, RD_DONE} state_t;

    state_t                                     state, state_nxt;
    logic                                       we_q;
    logic                                       wb_pending;
    logic [ADDR_WIDTH-1:0]                      wb_base;
    logic [ADDR_WIDTH-1:0]                      burst_base;
    logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0]  wb_data;
    logic [WORDS_PER_LINE-1:0][WORD_WIDTH-1:0]  rd_words;
    logic [CW-1:0]                              cnt;
    logic                                       wr_rise, wr_drop, wr_take, beat;

    // A second write-back edge has nowhere to go while one line is buffered or draining.
    assign wr_rise = write_en_mem & ~we_q;
    assign wr_drop = wr_rise & (wb_pending | (state == WB_BURST));
    assign wr_take = wr_rise & ~wr_drop;
    assign beat    = mem_ack & ((state == WB_BURST) | (state == RD_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                // A write captured this cycle must drain before any read starts.
                if (wb_pending)                 state_nxt = WB_BURST;
                else if (read_en_mem && !wr_take) state_nxt = RD_BURST;
            end
            WB_BURST: if (beat && cnt == LAST) state_nxt = IDLE;
            RD_BURST: if (beat && cnt == LAST) state_nxt = RD_DONE;
            RD_DONE:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            wb_pending   <= 1'b0;
            wb_base      <= '0;
            wb_data      <= '0;
            burst_base   <= '0;
            cnt          <= '0;
            protocol_err <= 1'b0;
            rd_words     <= '0;
        end else begin
            we_q <= write_en_mem;
            if (wr_drop) protocol_err <= 1'b1;
            if (wr_take) begin
                wb_pending <= 1'b1;
                wb_base    <= wb_addr & ~OFF_MASK;
                wb_data    <= wb_line;
            end
            if (state == IDLE && wb_pending) begin
                wb_pending <= 1'b0;
                burst_base <= wb_base;
            end else if (state == IDLE && read_en_mem && !wr_take) begin
                burst_base <= rd_addr & ~OFF_MASK;
            end
            // Power-of-two line length lets the counter wrap to 0 on the last beat.
            if (beat) cnt <= cnt + CW'(1);
            if (beat && state == RD_BURST) rd_words[cnt] <= mem_rdata;
        end
    end

    assign ready_mem = (state == RD_DONE);
    assign mem_req   = (state == WB_BURST) || (state == RD_BURST);
    assign mem_we    = (state == WB_BURST);
    assign mem_addr  = burst_base + ADDR_WIDTH'(cnt) * STRIDE;
    assign mem_wdata = mem_we ? wb_data[cnt] : '0;
    assign rd_line   = rd_words;
    assign busy      = (state != IDLE) || wb_pending;

endmodule

// File: tb/tb_line_fill_unit.sv
// Self-checking bench for line_fill_unit: directed table, multi-cycle corner
// sequences and randomized transactions against a line-level reference model.
module tb_line_fill_unit;

    localparam int AW = 32, WW = 32, WPL = 4, LW = WW * WPL;
    localparam int LINE_BYTES = WPL * WW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          read_en_mem, write_en_mem;
    logic [AW-1:0] rd_addr, wb_addr;
    logic [LW-1:0] wb_line;
    logic          ready_mem;
    logic [LW-1:0] rd_line;
    logic          busy, protocol_err, mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;
    logic          mem_ack;
    logic [WW-1:0] mem_rdata;

    int vectors = 0, miscompares = 0;
    int ack_period = 1;
    int ack_cnt = 0;
    logic [WW-1:0] salt = '0;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [WW-1:0] data;
    } xfer_t;
    xfer_t xq[$];

    int            stall_viol = 0;
    int            ready_cnt  = 0;
    logic          stalled    = 1'b0;
    logic [AW-1:0] stall_addr = '0;
    logic          stall_we   = 1'b0;

    line_fill_unit #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW), .WORDS_PER_LINE(WPL)) dut (
        .clk(clk), .rst(rst), .read_en_mem(read_en_mem), .write_en_mem(write_en_mem),
        .rd_addr(rd_addr), .wb_addr(wb_addr), .wb_line(wb_line), .ready_mem(ready_mem),
        .rd_line(rd_line), .busy(busy), .protocol_err(protocol_err), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    // Memory: acks after ack_period-1 stall cycles, read data is a function of address.
    assign mem_ack   = mem_req && (ack_cnt >= ack_period - 1);
    assign mem_rdata = salt ^ (32'hA0 + ((mem_addr >> 2) & 32'h3));

    always @(posedge clk) begin
        if (!mem_req || mem_ack) ack_cnt <= 0;
        else                     ack_cnt <= ack_cnt + 1;
    end

    always @(negedge clk) begin
        if (rst) begin
            stalled <= 1'b0;
        end else begin
            if (mem_req && mem_ack)
                xq.push_back('{mem_we, mem_addr, mem_we ? mem_wdata : mem_rdata});
            if (stalled && !(mem_req && mem_we == stall_we && mem_addr == stall_addr))
                stall_viol <= stall_viol + 1;
            stalled    <= mem_req && !mem_ack;
            stall_addr <= mem_addr;
            stall_we   <= mem_we;
            if (ready_mem) ready_cnt <= ready_cnt + 1;
        end
    end

    function automatic logic [WW-1:0] mem_model(logic [AW-1:0] a);
        return salt ^ (32'hA0 + ((a / 4) % 4));
    endfunction

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One controller transaction: optional write-back (2-cycle write_en_mem) plus a read
    // that rises dly cycles after the start; latency counted from the start cycle.
    task automatic run_txn(string nm, logic dirty, logic [AW-1:0] wa, logic [LW-1:0] wl,
                           logic [AW-1:0] ra, int per, int dly, int exp_lat,
                           logic [AW-1:0] exp_wb, logic [AW-1:0] exp_rd, logic exp_err);
        int n, first, r0;
        bit seen;
        logic [LW-1:0] exp_line;
        xfer_t e[$];
        ack_period = per;
        first = xq.size();
        r0 = ready_cnt;
        wb_addr = wa; wb_line = wl; rd_addr = ra;
        write_en_mem = dirty;
        read_en_mem = (dly == 0);
        n = 0; seen = 0;
        while (!seen && n < 400) begin
            tick(); n++;
            if (ready_mem) seen = 1;
            write_en_mem = dirty && n < 2;
            read_en_mem  = !seen && n >= dly;
        end
        check({nm, " ready seen"}, LW'(seen), LW'(1));
        check({nm, " latency"}, LW'(n), LW'(exp_lat));
        if (dirty)
            for (int i = 0; i < WPL; i++)
                e.push_back('{1'b1, exp_wb + AW'(4 * i), wl[i*WW +: WW]});
        for (int i = 0; i < WPL; i++) begin
            e.push_back('{1'b0, exp_rd + AW'(4 * i), mem_model(exp_rd + AW'(4 * i))});
            exp_line[i*WW +: WW] = mem_model(exp_rd + AW'(4 * i));
        end
        check({nm, " rd_line"}, rd_line, exp_line);
        for (int k = 0; k < 3; k++) begin
            tick();
            check({nm, " ready after"}, LW'(ready_mem), '0);
            check({nm, " req after"}, LW'(mem_req), '0);
        end
        check({nm, " busy"}, LW'(busy), '0);
        check({nm, " ready pulses"}, LW'(ready_cnt - r0), LW'(1));
        check({nm, " protocol_err"}, LW'(protocol_err), LW'(exp_err));
        check({nm, " stalls stable"}, LW'(stall_viol), '0);
        check({nm, " word count"}, LW'(xq.size() - first), LW'(e.size()));
        for (int i = 0; i < e.size(); i++)
            if (first + i < xq.size())
                check($sformatf("%s xfer%0d", nm, i),
                      LW'({xq[first+i].we, xq[first+i].addr, xq[first+i].data}),
                      LW'({e[i].we, e[i].addr, e[i].data}));
    endtask

    typedef struct {
        logic          dirty;
        logic [AW-1:0] wa;
        logic [LW-1:0] wl;
        logic [AW-1:0] ra;
        int            per;
        int            dly;
        int            lat;
        logic [AW-1:0] wbase;
        logic [AW-1:0] rbase;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int n, first, r0;
        logic [LW-1:0] l1, l2;

        tbl[0] = '{1'b0, 32'h0,      '0,                                          32'h1004,      1, 0, 5,  32'h0,    32'h1000};
        tbl[1] = '{1'b1, 32'h2000,   {32'h44, 32'h33, 32'h22, 32'h11},            32'h3000,      1, 2, 11, 32'h2000, 32'h3000};
        tbl[2] = '{1'b0, 32'h0,      '0,                                          32'h4008,      3, 0, 13, 32'h0,    32'h4000};
        tbl[3] = '{1'b1, 32'h501C,   {32'hDDDD, 32'hCCCC, 32'hBBBB, 32'hAAAA},    32'h6000,      1, 0, 11, 32'h5010, 32'h6000};
        tbl[4] = '{1'b1, 32'h7000,   {32'h7777, 32'h6666, 32'h5555, 32'h4444},    32'h8004,      3, 0, 27, 32'h7000, 32'h8000};
        tbl[5] = '{1'b0, 32'h0,      '0,                                          32'hFFFF_FFFF, 1, 1, 6,  32'h0,    32'hFFFF_FFF0};

        rst = 1'b1; read_en_mem = 0; write_en_mem = 0;
        rd_addr = '0; wb_addr = '0; wb_line = '0;
        #1;
        check("reset ready_mem", LW'(ready_mem), '0);
        check("reset mem_req", LW'(mem_req), '0);
        check("reset mem_we", LW'(mem_we), '0);
        check("reset mem_addr", LW'(mem_addr), '0);
        check("reset mem_wdata", LW'(mem_wdata), '0);
        check("reset rd_line", rd_line, '0);
        check("reset busy", LW'(busy), '0);
        check("reset protocol_err", LW'(protocol_err), '0);
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), tbl[i].dirty, tbl[i].wa, tbl[i].wl, tbl[i].ra,
                    tbl[i].per, tbl[i].dly, tbl[i].lat, tbl[i].wbase, tbl[i].rbase, 1'b0);

        // Overflow: second write edge while the first line is still draining.
        l1 = {32'h1234_0004, 32'h1234_0003, 32'h1234_0002, 32'h1234_0001};
        l2 = {32'hDEAD_0004, 32'hDEAD_0003, 32'hDEAD_0002, 32'hDEAD_0001};
        ack_period = 3; first = xq.size(); r0 = ready_cnt;
        wb_addr = 32'h9000; wb_line = l1; write_en_mem = 1;
        tick(); tick(); write_en_mem = 0;
        n = 0;
        while (!(mem_req && mem_we) && n < 50) begin tick(); n++; end
        check("ovf wb started", LW'(mem_req && mem_we), LW'(1));
        tick();
        wb_addr = 32'hB000; wb_line = l2; write_en_mem = 1;
        tick(); tick(); write_en_mem = 0;
        n = 0;
        while (busy && n < 100) begin tick(); n++; end
        check("ovf drained", LW'(busy), '0);
        check("ovf protocol_err", LW'(protocol_err), LW'(1));
        check("ovf word count", LW'(xq.size() - first), LW'(WPL));
        for (int i = 0; i < WPL; i++)
            if (first + i < xq.size())
                check($sformatf("ovf xfer%0d", i),
                      LW'({xq[first+i].we, xq[first+i].addr, xq[first+i].data}),
                      LW'({1'b1, 32'h9000 + AW'(4 * i), l1[i*WW +: WW]}));
        for (int k = 0; k < 5; k++) tick();
        check("ovf err sticky", LW'(protocol_err), LW'(1));
        check("ovf no extra burst", LW'(xq.size() - first), LW'(WPL));
        check("ovf no ready", LW'(ready_cnt - r0), '0);

        // Reset during a read burst once two words have been accepted.
        ack_period = 1; first = xq.size(); r0 = ready_cnt;
        rd_addr = 32'hA004; read_en_mem = 1;
        n = 0;
        while (xq.size() - first < 3 && n < 20) begin tick(); n++; end
        check("rst two acks done", LW'(xq.size() - first), LW'(3));
        rst = 1'b1; read_en_mem = 0;
        #1;
        check("rst mem_req", LW'(mem_req), '0);
        check("rst ready_mem", LW'(ready_mem), '0);
        check("rst busy", LW'(busy), '0);
        check("rst protocol_err", LW'(protocol_err), '0);
        check("rst mem_addr", LW'(mem_addr), '0);
        check("rst rd_line", rd_line, '0);
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("rst no ready", LW'(ready_cnt - r0), '0);
        run_txn("after rst", 1'b0, '0, '0, 32'hA004, 1, 0, 5, '0, 32'hA000, 1'b0);

        // Randomized transactions checked against line-level arithmetic.
        for (int t = 0; t < 30; t++) begin
            logic          d;
            logic [AW-1:0] wa, ra;
            logic [LW-1:0] wl;
            int            per, dly, lat, rd_seen;
            d   = 1'($urandom_range(0, 1));
            wa  = $urandom;
            ra  = $urandom;
            wl  = {$urandom, $urandom, $urandom, $urandom};
            per = $urandom_range(1, 3);
            dly = $urandom_range(0, 3);
            salt = $urandom;
            rd_seen = d ? ((2 + WPL * per > dly) ? 2 + WPL * per : dly) : dly;
            lat = rd_seen + 1 + WPL * per;
            run_txn($sformatf("rnd%0d", t), d, wa, wl, ra, per, dly, lat,
                    (wa / LINE_BYTES) * LINE_BYTES, (ra / LINE_BYTES) * LINE_BYTES, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
